// File: rtl/mac_accum_p.sv
// mac_accum_p: pipelined unsigned multiply-accumulate with saturate/wrap overflow and sample counter
module mac_accum_p #(
  parameter int W_IN        = 8,
  parameter int W_OUT       = 20,
  parameter int MULT_STAGES = 1,
  parameter int SAT         = 1,
  parameter int SQUARE      = 1,
  parameter int W_CNT       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W_IN-1:0]  a,
  input  logic [W_IN-1:0]  b,
  input  logic             valid_in,
  input  logic             clear,
  output logic [W_OUT-1:0] f,
  output logic             valid_out,
  output logic             overflow,
  output logic [W_CNT-1:0] count
);
  logic [W_IN-1:0]    a_q, b_q;
  logic               v_q;
  logic [2*W_IN-1:0]  full;
  logic [W_OUT-1:0]   prod, mp;
  logic               mv;
  logic [W_OUT-1:0]   acc_p_q;
  logic               acc_v_q;
  logic [W_OUT:0]     sum;
  logic [W_OUT-1:0]   f_q, f_d;
  logic               vo_q, ovf_q, ovf_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;
  // input capture: operands load only on valid, valid bit follows valid_in every edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= valid_in;
      if (valid_in) begin
        a_q <= a;
        b_q <= b;
      end
    end
  assign full = {{W_IN{1'b0}}, a_q} * {{W_IN{1'b0}}, (SQUARE != 0) ? a_q : b_q};
  assign prod = W_OUT'(full);
  generate
    if (MULT_STAGES == 0) begin : g_comb
      assign mp = prod;
      assign mv = v_q;
    end else begin : g_pipe
      logic [W_OUT-1:0]       pp_q [MULT_STAGES];
      logic [MULT_STAGES-1:0] pv_q;
      // product delay line, valid travels alongside its data
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          for (int i = 0; i < MULT_STAGES; i++) pp_q[i] <= '0;
          pv_q <= '0;
        end else begin
          pp_q[0] <= prod;
          pv_q[0] <= v_q;
          for (int i = 1; i < MULT_STAGES; i++) begin
            pp_q[i] <= pp_q[i-1];
            pv_q[i] <= pv_q[i-1];
          end
        end
      assign mp = pp_q[MULT_STAGES-1];
      assign mv = pv_q[MULT_STAGES-1];
    end
  endgenerate
  // accumulate-stage register holding the product about to be summed
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc_p_q <= '0;
      acc_v_q <= 1'b0;
    end else begin
      acc_p_q <= mp;
      acc_v_q <= mv;
    end
  assign sum = {1'b0, f_q} + {1'b0, acc_p_q};
  // next sum: clear restarts from the arriving product, carry saturates or wraps
  always_comb begin
    f_d   = clear ? (acc_v_q ? acc_p_q : '0) :
            !acc_v_q ? f_q :
            (sum[W_OUT] && SAT != 0) ? '1 : sum[W_OUT-1:0];
    ovf_d = clear ? 1'b0 : ovf_q | (acc_v_q & sum[W_OUT]);
    cnt_d = clear ? W_CNT'(acc_v_q) :
            (acc_v_q && cnt_q != '1) ? cnt_q + W_CNT'(1) : cnt_q;
  end
  // output registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      f_q   <= '0;
      vo_q  <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      vo_q  <= acc_v_q;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  assign f         = f_q;
  assign valid_out = vo_q;
  assign overflow  = ovf_q;
  assign count     = cnt_q;
endmodule

// File: tb/tb_mac_accum_p.sv
// tb_mac_accum_p: directed checks of default, wrap-mode and a*b/two-stage variants
module tb_mac_accum_p;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic        valid_in = 1'b0, clear = 1'b0;
  logic [19:0] f0, f1, f2;
  logic        vo0, vo1, vo2, ov0, ov1, ov2;
  logic [15:0] c0, c1, c2;
  int          checks = 0, errors = 0;
  int          sums [5] = '{1, 5, 14, 30, 55};
  int          idx;

  always #5 clk = ~clk;

  mac_accum_p u0 (.clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear(clear),
                  .f(f0), .valid_out(vo0), .overflow(ov0), .count(c0));
  mac_accum_p #(.SAT(0)) u1 (.clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear(clear),
                  .f(f1), .valid_out(vo1), .overflow(ov1), .count(c1));
  mac_accum_p #(.SQUARE(0), .MULT_STAGES(2)) u2 (.clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
                  .clear(clear), .f(f2), .valid_out(vo2), .overflow(ov2), .count(c2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_f0", 32'(f0), 0);
    chk("rst_vo0", 32'(vo0), 0);
    chk("rst_ov0", 32'(ov0), 0);
    chk("rst_c0", 32'(c0), 0);
    chk("rst_f2", 32'(f2), 0);
    tick();
    tick();
    reset = 1'b1;
    a = 8'd10;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    chk("single_early_vo", 32'(vo0), 0);
    tick();
    chk("single_early_vo2", 32'(vo0), 0);
    tick();
    chk("single_f", 32'(f0), 100);
    chk("single_vo", 32'(vo0), 1);
    chk("single_cnt", 32'(c0), 1);
    tick();
    chk("single_vo_drop", 32'(vo0), 0);
    chk("single_f_hold", 32'(f0), 100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_f", 32'(f0), 0);
    chk("clr_cnt", 32'(c0), 0);
    chk("clr_vo", 32'(vo0), 0);
    for (int t = 0; t < 9; t++) begin
      valid_in = (t < 5);
      a = 8'(t + 1);
      tick();
      if (t >= 3 && t <= 7) begin
        chk("stream_f", 32'(f0), 32'(sums[t-3]));
        chk("stream_vo", 32'(vo0), 1);
        chk("stream_cnt", 32'(c0), 32'(t - 2));
      end
      if (t == 8) chk("stream_vo_end", 32'(vo0), 0);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int t = 0; t < 22; t++) begin
      valid_in = (t < 19);
      a = 8'd255;
      tick();
      idx = t - 3;
      if (idx == 15) begin
        chk("sat_f16", 32'(f0), 1040400);
        chk("sat_ov16", 32'(ov0), 0);
        chk("wrap_f16", 32'(f1), 1040400);
      end
      if (idx == 16) begin
        chk("sat_f17", 32'(f0), 1048575);
        chk("sat_ov17", 32'(ov0), 1);
        chk("wrap_f17", 32'(f1), 56849);
        chk("wrap_ov17", 32'(ov1), 1);
      end
      if (idx == 18) begin
        chk("sat_hold", 32'(f0), 1048575);
        chk("sat_cnt", 32'(c0), 19);
        chk("wrap_f19", 32'(f1), 186899);
      end
    end
    a = 8'd2;
    valid_in = 1'b1;
    tick();
    a = 8'd3;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    chk("coll_pre_f", 32'(f0), 1048575);
    chk("coll_pre_ov", 32'(ov0), 1);
    chk("coll_pre_cnt", 32'(c0), 20);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("coll_f", 32'(f0), 9);
    chk("coll_cnt", 32'(c0), 1);
    chk("coll_ov", 32'(ov0), 0);
    chk("coll_vo", 32'(vo0), 1);
    chk("coll_ov_wrap", 32'(ov1), 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    a = 8'd4;
    b = 8'd5;
    valid_in = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    chk("mid_pre_f", 32'(f2), 20);
    chk("mid_pre_vo", 32'(vo2), 1);
    #2 reset = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("mid_rst_f", 32'(f2), 0);
    chk("mid_rst_vo", 32'(vo2), 0);
    chk("mid_rst_cnt", 32'(c2), 0);
    chk("mid_rst_f0", 32'(f0), 0);
    tick();
    reset = 1'b1;
    valid_in = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      valid_in = 1'b0;
      chk("mid_no_vo", 32'(vo2), 0);
    end
    tick();
    chk("mid_post_f", 32'(f2), 20);
    chk("mid_post_vo", 32'(vo2), 1);
    chk("mid_post_cnt", 32'(c2), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
